// File: rtl/line_merge_3_if.sv
// AXI4-Stream bundle shared by the line buffers and the merge stage.
interface axi4_stream_if #(
  parameter int TDATA_WIDTH = 32,
  parameter int TID_WIDTH   = 4,
  parameter int TDEST_WIDTH = 4,
  parameter int TUSER_WIDTH = 1
);
  logic                         tvalid;
  logic                         tready;
  logic [TDATA_WIDTH-1:0]       tdata;
  logic [(TDATA_WIDTH+7)/8-1:0] tstrb;
  logic [(TDATA_WIDTH+7)/8-1:0] tkeep;
  logic                         tlast;
  logic [TID_WIDTH-1:0]         tid;
  logic [TDEST_WIDTH-1:0]       tdest;
  logic [TUSER_WIDTH-1:0]       tuser;

  modport master (output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser, input tready);
  modport slave  (input tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser, output tready);
endinterface

// File: rtl/line_merge_3.sv
// Pops three line buffers together and joins their pixel streams into one
// column-per-beat stream for vertical/3x3 filters.
module line_merge_3_lane (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr,
  input  logic stream,
  input  logic drain,
  input  logic join_ok,
  input  logic tvalid,
  input  logic tlast,
  output logic tready,
  output logic done
);
  // Joined lanes move together; while draining, each lane runs alone to its tlast.
  assign tready = (stream && join_ok) || (drain && !done);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                      done <= 1'b0;
    else if (clr)                      done <= 1'b0;
    else if (tvalid && tready && tlast) done <= 1'b1;
  end
endmodule

module line_merge_3 #(
  parameter int PX_WIDTH      = 30,
  parameter int TDATA_WIDTH_I = 32,
  parameter int TDATA_WIDTH_O = 96
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  axi4_stream_if.slave  line0_i,
  axi4_stream_if.slave  line1_i,
  axi4_stream_if.slave  line2_i,
  input  logic [2:0]    unread_i,
  input  logic [2:0]    empty_i,
  output logic [2:0]    pop_line_o,
  axi4_stream_if.master video_o,
  output logic          tlast_err_o
);
  localparam int NUM_LANES = 3;

  typedef enum logic [1:0] {IDLE, POP, STREAM, DRAIN} state_t;

  typedef struct packed {
    logic [TDATA_WIDTH_O-1:0] tdata;
    logic                     tlast;
    logic                     tuser;
  } beat_t;

  state_t                               state;
  beat_t                                out_q;
  logic                                 out_vld;
  logic [NUM_LANES-1:0]                 in_vld, in_last, in_user, in_rdy, done, acc;
  logic [NUM_LANES-1:0][PX_WIDTH-1:0]   in_px;
  logic [TDATA_WIDTH_O-1:0]             col_px;
  logic                                 all_v, can_load, join_ok, join_acc, all_done_nxt;
  logic                                 unused_in;

  assign in_vld  = {line2_i.tvalid, line1_i.tvalid, line0_i.tvalid};
  assign in_last = {line2_i.tlast,  line1_i.tlast,  line0_i.tlast};
  assign in_user = {|line2_i.tuser, |line1_i.tuser, |line0_i.tuser};
  assign in_px   = {line2_i.tdata[PX_WIDTH-1:0], line1_i.tdata[PX_WIDTH-1:0],
                    line0_i.tdata[PX_WIDTH-1:0]};

  assign line0_i.tready = in_rdy[0];
  assign line1_i.tready = in_rdy[1];
  assign line2_i.tready = in_rdy[2];

  assign unused_in = ^{line0_i.tdata, line0_i.tstrb, line0_i.tkeep, line0_i.tid, line0_i.tdest,
                       line1_i.tdata, line1_i.tstrb, line1_i.tkeep, line1_i.tid, line1_i.tdest,
                       line2_i.tdata, line2_i.tstrb, line2_i.tkeep, line2_i.tid, line2_i.tdest};

  assign all_v        = &in_vld;
  assign can_load     = !out_vld || video_o.tready;
  assign join_ok      = all_v && can_load;
  assign join_acc     = (state == STREAM) && join_ok;
  assign acc          = in_vld & in_rdy;
  assign all_done_nxt = &(done | (acc & in_last));

  // Top row in the LSBs, bottom row above it, zero-extended to the output width.
  always_comb begin
    col_px = '0;
    col_px[NUM_LANES*PX_WIDTH-1:0] = in_px;
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    line_merge_3_lane u_lane (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .clr     (state == POP),
      .stream  (state == STREAM),
      .drain   (state == DRAIN),
      .join_ok (join_ok),
      .tvalid  (in_vld[i]),
      .tlast   (in_last[i]),
      .tready  (in_rdy[i]),
      .done    (done[i])
    );
  end

  // can_load in IDLE keeps a pending tlast from being overtaken by the next pop.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= IDLE;
      pop_line_o  <= '0;
      tlast_err_o <= 1'b0;
    end else begin
      pop_line_o  <= '0;
      tlast_err_o <= 1'b0;
      case (state)
        IDLE: if (unread_i == 3'b111 && empty_i == 3'b000 && can_load) begin
          state      <= POP;
          pop_line_o <= 3'b111;
        end
        POP: state <= STREAM;
        STREAM: if (join_acc && |in_last) begin
          state       <= (&in_last) ? IDLE : DRAIN;
          tlast_err_o <= !(&in_last);
        end
        DRAIN: if (all_done_nxt) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_vld <= 1'b0;
      out_q   <= '0;
    end else if (join_acc) begin
      out_vld     <= 1'b1;
      out_q.tdata <= col_px;
      out_q.tlast <= |in_last;
      out_q.tuser <= |in_user;
    end else if (video_o.tready) begin
      out_vld <= 1'b0;
    end
  end

  assign video_o.tvalid = out_vld;
  assign video_o.tdata  = out_q.tdata;
  assign video_o.tlast  = out_q.tlast;
  assign video_o.tuser  = out_q.tuser;
  assign video_o.tstrb  = '1;
  assign video_o.tkeep  = '1;
  assign video_o.tid    = '0;
  assign video_o.tdest  = '0;
endmodule

// File: tb/tb_line_merge_3.sv
// Directed bench for line_merge_3: a queue-based line model checked every output-valid cycle.
module tb_line_merge_3;
  localparam int PX = 30;
  localparam int WI = 32;
  localparam int WO = 96;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi4_stream_if #(.TDATA_WIDTH(WI)) l0 ();
  axi4_stream_if #(.TDATA_WIDTH(WI)) l1 ();
  axi4_stream_if #(.TDATA_WIDTH(WI)) l2 ();
  axi4_stream_if #(.TDATA_WIDTH(WO)) vo ();

  logic [2:0]         unread, empty, pop;
  logic               terr;
  logic [2:0]         l_vld, l_last, l_user;
  logic [2:0][WI-1:0] l_data;
  logic               out_rdy;
  logic [2:0]         l_rdy;

  assign l0.tvalid = l_vld[0]; assign l0.tdata = l_data[0]; assign l0.tlast = l_last[0];
  assign l1.tvalid = l_vld[1]; assign l1.tdata = l_data[1]; assign l1.tlast = l_last[1];
  assign l2.tvalid = l_vld[2]; assign l2.tdata = l_data[2]; assign l2.tlast = l_last[2];
  assign l0.tuser = l_user[0]; assign l1.tuser = l_user[1]; assign l2.tuser = l_user[2];
  assign l0.tstrb = '1; assign l0.tkeep = '1; assign l0.tid = '0; assign l0.tdest = '0;
  assign l1.tstrb = '1; assign l1.tkeep = '1; assign l1.tid = '0; assign l1.tdest = '0;
  assign l2.tstrb = '1; assign l2.tkeep = '1; assign l2.tid = '0; assign l2.tdest = '0;
  assign vo.tready = out_rdy;
  assign l_rdy = {l2.tready, l1.tready, l0.tready};

  line_merge_3 #(.PX_WIDTH(PX), .TDATA_WIDTH_I(WI), .TDATA_WIDTH_O(WO)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .line0_i     (l0),
    .line1_i     (l1),
    .line2_i     (l2),
    .unread_i    (unread),
    .empty_i     (empty),
    .pop_line_o  (pop),
    .video_o     (vo),
    .tlast_err_o (terr)
  );

  typedef struct packed {
    logic [WO-1:0] d;
    logic          l;
    logic          u;
  } beat_t;

  beat_t         expq[$];
  int            n_cmp = 0;
  int            n_fail = 0;
  int            pop_cnt = 0;
  int            err_cnt = 0;
  int            out_cnt = 0;
  bit            mm = 1'b0;
  logic [WO-1:0] out_log[16];
  logic          out_ulog[16];

  task automatic check_i(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic check_d(input string name, input logic [WO-1:0] act, input logic [WO-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic logic [WI-1:0] px(input int ln, input int k, input bit big);
    return big ? WI'(((ln + 1) << 16) | k) : WI'(16 * (ln + 1) + k);
  endfunction

  // Any valid output beat must be the oldest outstanding column of the model.
  task automatic monitor_cycle();
    beat_t e;
    if (!rst_n) return;
    if (vo.tvalid) begin
      if (expq.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL extra_beat: got %h, want no beat", vo.tdata);
      end else begin
        e = expq[0];
        check_d("beat_data", vo.tdata, e.d);
        check_i("beat_last", int'(vo.tlast), int'(e.l));
        check_i("beat_user", int'(vo.tuser), int'(e.u));
        if (vo.tready) void'(expq.pop_front());
      end
      if (vo.tready) begin
        if (out_cnt < 16) begin
          out_log[out_cnt]  = vo.tdata;
          out_ulog[out_cnt] = vo.tuser[0];
        end
        out_cnt++;
      end
    end
    if (pop != 3'b000) begin
      check_i("pop_value", int'(pop), 7);
      pop_cnt++;
    end
    if (terr) err_cnt++;
    if (!mm) check_i("lanes_together", int'(l_rdy == 3'b000 || l_rdy == 3'b111), 1);
  endtask

  task automatic check_reset(input string tag);
    check_i({tag, "_tvalid"}, int'(vo.tvalid), 0);
    check_d({tag, "_tdata"}, vo.tdata, '0);
    check_i({tag, "_tlast"}, int'(vo.tlast), 0);
    check_i({tag, "_tuser"}, int'(vo.tuser), 0);
    check_i({tag, "_pop"}, int'(pop), 0);
    check_i({tag, "_tready"}, int'(l_rdy), 0);
    check_i({tag, "_err"}, int'(terr), 0);
  endtask

  task automatic run_line(input int len0, input int len1, input int len2, input int gap,
                          input int rdy_pct, input int user_ln, input bit big, input int abort_at);
    int            len[3];
    int            idx[3];
    bit            acc[3];
    int            mn, cyc;
    beat_t         b;
    logic [WI-1:0] a0, a1, a2;
    len = '{len0, len1, len2};
    mn = len0;
    if (len1 < mn) mn = len1;
    if (len2 < mn) mn = len2;
    mm = !(len0 == len1 && len1 == len2);
    for (int k = 0; k < mn; k++) begin
      a0 = px(0, k, big); a1 = px(1, k, big); a2 = px(2, k, big);
      b.d = '0;
      b.d[PX-1:0]      = a0[PX-1:0];
      b.d[2*PX-1:PX]   = a1[PX-1:0];
      b.d[3*PX-1:2*PX] = a2[PX-1:0];
      b.l = (k == mn - 1);
      b.u = (user_ln >= 0 && k == 0);
      expq.push_back(b);
    end
    out_cnt = 0;
    idx = '{0, 0, 0};
    l_vld = '0; l_last = '0; l_user = '0;
    unread = 3'b111; empty = 3'b000;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc > 50) begin
        check_i("pop_timeout", int'(pop), 7);
        unread = 3'b000; expq.delete();
        return;
      end
    end while (pop !== 3'b111);
    @(posedge clk); #1;
    unread = 3'b000;
    cyc = 0;
    forever begin
      for (int i = 0; i < 3; i++)
        if (!l_vld[i] && idx[i] < len[i] && $urandom_range(99) >= gap) begin
          l_vld[i]  = 1'b1;
          l_data[i] = px(i, idx[i], big);
          l_last[i] = (idx[i] == len[i] - 1);
          l_user[i] = (i == user_ln && idx[i] == 0);
        end
      out_rdy = ($urandom_range(99) < rdy_pct);
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 3; i++) acc[i] = l_vld[i] && l_rdy[i];
      if (abort_at >= 0 && out_cnt >= abort_at) begin
        rst_n = 1'b0;
        #1;
        check_reset("midrst");
        expq.delete();
        l_vld = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        return;
      end
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++)
        if (acc[i]) begin idx[i]++; l_vld[i] = 1'b0; end
      if (idx[0] == len[0] && idx[1] == len[1] && idx[2] == len[2] && expq.size() == 0) break;
      if (cyc > 20000) begin
        check_i("line_timeout_outstanding", expq.size(), 0);
        expq.delete();
        break;
      end
    end
    l_vld = '0;
    out_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int p0, e0;
    unread = '0; empty = '0; out_rdy = 1'b1;
    l_vld = '0; l_last = '0; l_user = '0; l_data = '0;
    fork
      forever begin @(negedge clk); monitor_cycle(); end
    join_none
    repeat (3) @(posedge clk);
    #1 check_reset("reset");
    rst_n = 1'b1;

    // Basic 8-px line, continuous flow.
    p0 = pop_cnt; e0 = err_cnt;
    run_line(8, 8, 8, 0, 100, -1, 1'b0, -1);
    check_i("t1_pops", pop_cnt - p0, 1);
    check_i("t1_beats", out_cnt, 8);
    check_i("t1_err", err_cnt - e0, 0);
    check_d("t1_beat0", out_log[0], 96'h3_0000_0008_0000_0010);
    check_d("t1_beat7", out_log[7], 96'h3_7000_0009_C000_0017);

    // Partial readiness must never pop.
    p0 = pop_cnt;
    unread = 3'b011;
    repeat (10) @(posedge clk);
    #1 check_i("t2_no_pop_partial", pop_cnt - p0, 0);
    unread = 3'b111; empty = 3'b010;
    repeat (10) @(posedge clk);
    #1 check_i("t2_no_pop_empty", pop_cnt - p0, 0);
    unread = 3'b000; empty = 3'b000;
    run_line(8, 8, 8, 0, 100, -1, 1'b0, -1);
    check_i("t2_pops", pop_cnt - p0, 1);
    check_i("t2_beats", out_cnt, 8);

    // tuser on line1 first beat.
    run_line(8, 8, 8, 0, 100, 1, 1'b0, -1);
    check_i("t3_user0", int'(out_ulog[0]), 1);
    check_i("t3_user1", int'(out_ulog[1]), 0);

    // Length mismatch: line0 ends after 6 px.
    p0 = pop_cnt; e0 = err_cnt;
    run_line(6, 8, 8, 0, 100, -1, 1'b0, -1);
    check_i("t4_err_pulses", err_cnt - e0, 1);
    check_i("t4_beats", out_cnt, 6);
    check_d("t4_beat5", out_log[5], 96'h3_5000_0009_4000_0015);
    check_i("t4_pops", pop_cnt - p0, 1);

    // Reset in the middle of a line, then a fresh full line.
    run_line(8, 8, 8, 0, 100, -1, 1'b0, 4);
    check_i("t5_beats_before_rst", out_cnt, 4);
    p0 = pop_cnt;
    run_line(8, 8, 8, 0, 100, -1, 1'b0, -1);
    check_i("t5_pops", pop_cnt - p0, 1);
    check_i("t5_beats", out_cnt, 8);

    // Full-width line with input gaps and output backpressure.
    p0 = pop_cnt; e0 = err_cnt;
    run_line(1920, 1920, 1920, 30, 50, -1, 1'b1, -1);
    check_i("t6_beats", out_cnt, 1920);
    check_i("t6_pops", pop_cnt - p0, 1);
    check_i("t6_err", err_cnt - e0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
